// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB plus an iterative shift-add
// multiplier that holds off new requests through ready_o while busy.
//
// state  | meaning
// S_IDLE | accepting requests; logic/arith ops complete at the accepting edge
// S_MUL  | shift-add iterations in progress, ready_o low
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             ovf_nxt;
  logic             illegal_nxt;
  logic             valid_nxt;
  logic             zero_nxt;
  logic             load_result;

  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_step;
  logic             ovf_add;
  logic             ovf_sub;

  assign ready_o  = (state == S_IDLE);
  assign accept   = valid_i && ready_o;
  assign sum      = data1_i + data2_i;
  assign diff     = data1_i - data2_i;
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  // Carry-out is dropped; overflow is judged from operand and result sign bits only.
  assign ovf_add = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (sum[WIDTH-1]  != data1_i[WIDTH-1]);
  assign ovf_sub = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (diff[WIDTH-1] != data1_i[WIDTH-1]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      data_o    <= '0;
      zero_o    <= 1'b1;
      ovf_o     <= 1'b0;
      illegal_o <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      acc       <= acc_nxt;
      data_o    <= data_nxt;
      zero_o    <= zero_nxt;
      ovf_o     <= ovf_nxt;
      illegal_o <= illegal_nxt;
      valid_o   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    acc_nxt     = acc;
    data_nxt    = data_o;
    ovf_nxt     = ovf_o;
    illegal_nxt = illegal_o;
    valid_nxt   = 1'b0;
    load_result = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (ALUCtrl_i)
            OP_AND: begin
              data_nxt    = data1_i & data2_i;
              ovf_nxt     = 1'b0;
              illegal_nxt = 1'b0;
              valid_nxt   = 1'b1;
              load_result = 1'b1;
            end
            OP_OR: begin
              data_nxt    = data1_i | data2_i;
              ovf_nxt     = 1'b0;
              illegal_nxt = 1'b0;
              valid_nxt   = 1'b1;
              load_result = 1'b1;
            end
            OP_ADD: begin
              data_nxt    = sum;
              ovf_nxt     = ovf_add;
              illegal_nxt = 1'b0;
              valid_nxt   = 1'b1;
              load_result = 1'b1;
            end
            OP_SUB: begin
              data_nxt    = diff;
              ovf_nxt     = ovf_sub;
              illegal_nxt = 1'b0;
              valid_nxt   = 1'b1;
              load_result = 1'b1;
            end
            OP_MUL: begin
              mcand_nxt  = data1_i;
              mplier_nxt = data2_i;
              acc_nxt    = '0;
              cnt_nxt    = '0;
              state_nxt  = S_MUL;
            end
            default: begin
              data_nxt    = '0;
              ovf_nxt     = 1'b0;
              illegal_nxt = 1'b1;
              valid_nxt   = 1'b1;
              load_result = 1'b1;
            end
          endcase
        end
      end

      S_MUL: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        // Fixed WIDTH iterations; the final one is folded straight into data_o.
        if (cnt == CNT_LAST) begin
          data_nxt    = acc_step;
          ovf_nxt     = 1'b0;
          illegal_nxt = 1'b0;
          valid_nxt   = 1'b1;
          load_result = 1'b1;
          state_nxt   = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    zero_nxt = load_result ? (data_nxt == '0) : zero_o;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=32): reset, arithmetic/logic
// ops, overflow, back-to-back issue, multiplier timing, illegal codes, mid-MUL reset.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             ovf_o;
  logic             illegal_o;

  int tests_run = 0;
  int tests_failed = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o),
    .illegal_o (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk_i);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  task automatic idle_inputs();
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    valid_i = 1'b0;
    ALUCtrl_i = 3'b000;
    data1_i = '0;
    data2_i = '0;
    #12;
    tests_run++;
    if ({data_o, zero_o, ovf_o, valid_o, illegal_o} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: data=%h z=%b o=%b v=%b i=%b, want data=0 z=1 o=0 v=0 i=0",
               data_o, zero_o, ovf_o, valid_o, illegal_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({ready_o, valid_o, data_o, zero_o} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: rdy=%b v=%b data=%h z=%b, want rdy=1 v=0 data=0 z=1",
               ready_o, valid_o, data_o, zero_o);
    end
  endtask

  task automatic test_add_sub();
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, ovf_o, zero_o, illegal_o} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_ovf: v=%b data=%h o=%b z=%b i=%b, want v=1 data=80000000 o=1 z=0 i=0",
               valid_o, data_o, ovf_o, zero_o, illegal_o);
    end
    idle_inputs();
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, ovf_o} !== {1'b0, 32'h8000_0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL idle_hold: v=%b data=%h o=%b, want v=0 data=80000000 o=1", valid_o, data_o, ovf_o);
    end
    issue(3'b011, 32'd5, 32'd5);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, zero_o, ovf_o} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub_zero: v=%b data=%h z=%b o=%b, want v=1 data=0 z=1 o=0", valid_o, data_o, zero_o, ovf_o);
    end
    issue(3'b011, 32'h8000_0000, 32'h1);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, zero_o, ovf_o} !== {1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub_ovf: v=%b data=%h z=%b o=%b, want v=1 data=7fffffff z=0 o=1", valid_o, data_o, zero_o, ovf_o);
    end
    issue(3'b010, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({data_o, zero_o, ovf_o} !== {32'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_carry: data=%h z=%b o=%b, want data=0 z=1 o=0", data_o, zero_o, ovf_o);
    end
    idle_inputs();
  endtask

  task automatic test_logic();
    issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, ovf_o} !== {1'b1, 32'hF000_F000, 1'b0}) begin
      tests_failed++;
      $display("FAIL and: v=%b data=%h o=%b, want v=1 data=f000f000 o=0", valid_o, data_o, ovf_o);
    end
    issue(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, zero_o} !== {1'b1, 32'hFFF0_FFF0, 1'b0}) begin
      tests_failed++;
      $display("FAIL or: v=%b data=%h z=%b, want v=1 data=fff0fff0 z=0", valid_o, data_o, zero_o);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [2:0]       ops [4];
    logic [WIDTH-1:0] as  [4];
    logic [WIDTH-1:0] bs  [4];
    logic [WIDTH-1:0] exp [4];
    ops = '{3'b010, 3'b011, 3'b000, 3'b001};
    as  = '{32'd1, 32'd10, 32'hC, 32'hC};
    bs  = '{32'd2, 32'd3, 32'hA, 32'hA};
    exp = '{32'd3, 32'd7, 32'h8, 32'hE};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(posedge clk_i);
      #1;
      tests_run++;
      if ({valid_o, ready_o, data_o} !== {1'b1, 1'b1, exp[i]}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: v=%b rdy=%b data=%h, want v=1 rdy=1 data=%h", i, valid_o, ready_o, data_o, exp[i]);
      end
    end
    idle_inputs();
    @(posedge clk_i);
    #1;
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: v=%b, want v=0", valid_o);
    end
  endtask

  task automatic run_mul(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] expected);
    int busy_err;
    busy_err = 0;
    issue(3'b110, a, b);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({ready_o, valid_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s_accept: rdy=%b v=%b, want rdy=0 v=0", name, ready_o, valid_o);
    end
    // Keep a different request pending while busy; it must never be taken.
    issue(3'b010, 32'd1, 32'd1);
    for (int k = 1; k < WIDTH; k++) begin
      @(posedge clk_i);
      #1;
      if (ready_o !== 1'b0 || valid_o !== 1'b0) busy_err++;
    end
    tests_run++;
    if (busy_err != 0) begin
      tests_failed++;
      $display("FAIL %s_busy: %0d cycles with rdy/v high during MUL, want 0", name, busy_err);
    end
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, ready_o, data_o, ovf_o, illegal_o} !== {1'b1, 1'b1, expected, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s_result: v=%b rdy=%b data=%h o=%b i=%b, want v=1 rdy=1 data=%h o=0 i=0",
               name, valid_o, ready_o, data_o, ovf_o, illegal_o, expected);
    end
    idle_inputs();
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o} !== {1'b0, expected}) begin
      tests_failed++;
      $display("FAIL %s_after: v=%b data=%h, want v=0 data=%h", name, valid_o, data_o, expected);
    end
  endtask

  task automatic test_mul();
    run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652);
    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_mul("mul_zero", 32'hDEAD_BEEF, 32'h0, 32'h0);
  endtask

  task automatic test_illegal();
    issue(3'b111, 32'd7, 32'd7);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, illegal_o, zero_o, ovf_o, ready_o} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL illegal_111: v=%b data=%h i=%b z=%b o=%b rdy=%b, want v=1 data=0 i=1 z=1 o=0 rdy=1",
               valid_o, data_o, illegal_o, zero_o, ovf_o, ready_o);
    end
    issue(3'b100, 32'd9, 32'd9);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, illegal_o, ready_o} !== 3'b111) begin
      tests_failed++;
      $display("FAIL illegal_100: v=%b i=%b rdy=%b, want v=1 i=1 rdy=1", valid_o, illegal_o, ready_o);
    end
    issue(3'b010, 32'd100, 32'd1);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, illegal_o} !== {1'b1, 32'd101, 1'b0}) begin
      tests_failed++;
      $display("FAIL illegal_clear: v=%b data=%h i=%b, want v=1 data=00000065 i=0", valid_o, data_o, illegal_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    stray = 0;
    issue(3'b110, 32'd3, 32'd4);
    @(posedge clk_i);
    idle_inputs();
    for (int k = 0; k < 10; k++) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({data_o, zero_o, valid_o, ready_o} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_mul_async: data=%h z=%b v=%b rdy=%b, want data=0 z=1 v=0 rdy=1",
               data_o, zero_o, valid_o, ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL mid_mul_abort: %0d cycles with v high or rdy low after reset, want 0", stray);
    end
    issue(3'b010, 32'd2, 32'd3);
    @(posedge clk_i);
    #1;
    tests_run++;
    if ({valid_o, data_o, zero_o, ovf_o} !== {1'b1, 32'd5, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL post_reset_add: v=%b data=%h z=%b o=%b, want v=1 data=00000005 z=0 o=0",
               valid_o, data_o, zero_o, ovf_o);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 3-bit ALUCtrl code produced by the ALU control decoder and performs the operation on two operands.
- AND/OR/ADD/SUB complete with 1-cycle registered latency.
- MUL is an iterative shift-add multiplier that holds off new requests via a valid/ready handshake.
- Sits between the ID/EX pipeline register and the EX/MEM register; the hazard unit stalls the pipeline while ready_o is low.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  request valid; the operation is accepted when valid_i && ready_o at a rising edge.
- ALUCtrl_i  input  3  operation code: 000 AND, 001 OR, 010 ADD, 011 SUB, 110 MUL; others illegal.
- data1_i  input  WIDTH  operand A (multiplicand for MUL).
- data2_i  input  WIDTH  operand B (multiplier for MUL).
- ready_o  output  1  unit can accept a request; combinational, equals (state==IDLE).
- valid_o  output  1  one-cycle pulse marking data_o/flags as new.
- data_o  output  WIDTH  registered result.
- zero_o  output  1  registered; 1 when data_o==0.
- ovf_o  output  1  registered signed overflow for ADD/SUB; 0 for all other ops.
- illegal_o  output  1  registered; 1 with valid_o when the code was illegal.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0, internal accumulator/operand registers=0.
  - data_o=0, zero_o=1, ovf_o=0, valid_o=0, illegal_o=0.
  - ready_o=1 as soon as reset releases.
- States are IDLE and MUL. There is no separate done state.
- IDLE, no accept:
  - valid_o=0 at the next edge.
  - data_o and flags hold their last values.
- IDLE, accept, code in {000,001,010,011}:
  - At the accepting edge, data_o = A&B, A|B, A+B or A−B, truncated to WIDTH; valid_o=1 for exactly one cycle.
  - Latency is 1 cycle. State remains IDLE.
- Signed overflow:
  - ADD: ovf_o = (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
  - SUB: ovf_o = (A[msb]!=B[msb]) && (diff[msb]!=A[msb]).
  - Carry-out is discarded.
- IDLE, accept, illegal code (100/101/111):
  - data_o=0, zero_o=1, ovf_o=0, illegal_o=1, valid_o=1 for one cycle. State remains IDLE.
- IDLE, accept, MUL (110):
  - At the accepting edge: mcand←A, mplier←B, acc←0, counter←0, state←MUL. valid_o=0.
- In MUL, each edge performs one iteration:
  - If mplier[0], acc←acc+mcand.
  - Then mcand←mcand<<1, mplier←mplier>>1, counter←counter+1.
  - All arithmetic is modulo 2**WIDTH; only the low WIDTH product bits are kept, unsigned/two's-complement low-half equivalent.
- MUL completion:
  - At the edge where counter==WIDTH−1, the last iteration is folded in.
  - data_o←final acc, zero_o updated, ovf_o=0, illegal_o=0, valid_o=1, state←IDLE.
  - MUL latency is exactly WIDTH cycles from the accepting edge. There is no early termination.
- Handshakes and stalls:
  - ready_o=0 for the whole MUL state; valid_i/ALUCtrl_i/data inputs are ignored there.
  - A new request is accepted in the same cycle valid_o is high (back-to-back, no bubble).
- Reset mid-MUL: the operation is aborted with no valid_o pulse, and all outputs take their reset values.
- zero_o is always computed from the value being loaded into data_o, in the same edge.
- illegal_o and ovf_o are meaningful only while valid_o=1.
- Counter wrap cannot occur because MUL exits at WIDTH−1.

Test Plan:
1. Reset held low, then released → data_o=0, zero_o=1, valid_o=0, ready_o=1. Assert rst_i low mid-operation → outputs clear asynchronously, before the next edge.
2. ADD A=0x7FFFFFFF, B=1 → next cycle data_o=0x80000000, ovf_o=1, valid_o one pulse. SUB A=5, B=5 → data_o=0, zero_o=1, ovf_o=0.
3. AND 0xF0F0F0F0,0xFF00FF00 → data_o=0xF000F000. OR the same operands → 0xFFF0FFF0. Drive 4 back-to-back requests with valid_i held high → 4 consecutive valid_o pulses.
4. MUL A=1234, B=5678 → ready_o low for 32 cycles, valid_o at edge 32 after accept, data_o=7006652. MUL 0xFFFFFFFF×0xFFFFFFFF → data_o=1. Hold valid_i during busy → no extra accepts.
5. Illegal code 111 with A=B=7 → data_o=0, illegal_o=1, zero_o=1, valid_o pulse. Reset pulse at cycle 10 of a MUL → no valid_o, ready_o=1 after release; a following ADD 2+3 → data_o=5.
